// File: rtl/ddu_debug_unit.sv
// Debug/display front end for the multicycle CPU: buttons -> cont/run/ddu_addr, data -> 7-seg/LEDs.
// Define DDU_STEP_COUNT_EN to count single-step pulses on o_step_cnt.
module ddu_debug_unit #(
    parameter int DEB_CYCLES = 1000000,
    parameter int SCAN_DIV   = 100000,
    parameter int ADDR_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cont_sw,
    input  logic        i_step_btn,
    input  logic        i_inc_btn,
    input  logic        i_dec_btn,
    input  logic        i_mem_sel,
    input  logic [31:0] i_mem_data,
    input  logic [31:0] i_reg_data,
    input  logic [31:0] i_pc,
    output logic        o_cont,
    output logic        o_run,
    output logic [31:0] o_ddu_addr,
    output logic [7:0]  o_an,
    output logic [7:0]  o_seg,
    output logic [15:0] o_led,
    output logic [15:0] o_step_cnt
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [2:0]        w_deb;
    logic [2:0]        r_deb_q;
    logic [2:0]        r_pulse;
    logic              r_run;
    logic [ADDR_W-1:0] r_addr;
    logic [SW-1:0]     r_div;
    logic [2:0]        r_idx;
    logic [7:0]        r_an;
    logic [7:0]        r_seg;
    logic [7:0]        w_seg;
    logic [15:0]       r_led;
    logic [31:0]       w_word;
    logic [3:0]        w_nib;
    logic              w_unused;

    // bit order {dec, inc, step, cont}
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_dec_btn, i_inc_btn, i_step_btn, i_cont_sw};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [DW-1:0] r_cnt;
        logic          r_lvl;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[g+1] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                r_lvl <= r_sync2[g+1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end

        assign w_deb[g] = r_lvl;
    end

    // pulse bits {dec, inc, step}
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_deb_q <= '0;
            r_pulse <= '0;
            r_run   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_deb_q <= w_deb;
            r_pulse <= w_deb & ~r_deb_q;
            r_run   <= r_pulse[0] & ~r_sync2[0];
            case ({r_pulse[2], r_pulse[1]})
                2'b01:   r_addr <= r_addr + ADDR_W'(1);
                2'b10:   r_addr <= r_addr - ADDR_W'(1);
                default: r_addr <= r_addr;
            endcase
        end
    end

    assign w_word = i_mem_sel ? i_mem_data : i_reg_data;
    assign w_nib  = w_word[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = 8'hFF;
        case (w_nib)
            4'h0: w_seg = 8'hC0;
            4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;
            4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;
            4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;
            4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;
            4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;
            4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;
            4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;
            4'hF: w_seg = 8'h8E;
            default: w_seg = 8'hFF;
        endcase
    end

    // an/seg come from the pre-increment index so every digit gets a full SCAN_DIV
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
            r_led <= '0;
        end else begin
            if (r_div == SW'(SCAN_DIV - 1)) begin
                r_div <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_div <= r_div + SW'(1);
            end
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= w_seg;
            r_led <= {o_ddu_addr[7:0], i_pc[9:2]};
        end
    end

`ifdef DDU_STEP_COUNT_EN
    logic        r_cont_d;
    logic [15:0] r_step_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cont_d   <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_cont_d <= r_sync2[0];
            if (r_sync2[0] & ~r_cont_d)
                r_step_cnt <= '0;
            else if (r_run)
                r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    assign o_step_cnt = r_step_cnt;
`else
    assign o_step_cnt = 16'd0;
`endif

    assign w_unused   = &{1'b0, i_pc[31:10], i_pc[1:0]};
    assign o_cont     = r_sync2[0];
    assign o_run      = r_run;
    assign o_ddu_addr = {{(32 - ADDR_W){1'b0}}, r_addr};
    assign o_an       = r_an;
    assign o_seg      = r_seg;
    assign o_led      = r_led;

endmodule

// File: tb/tb_ddu_debug_unit.sv
// Bench for ddu_debug_unit: directed plan steps plus random traffic against a windowed reference model.
module tb_ddu_debug_unit;

    localparam int DEB = 4;
    localparam int SD  = 4;

    logic        clk = 1'b0;
    logic        rst_n, cont_sw, step_btn, inc_btn, dec_btn, mem_sel;
    logic [31:0] mem_data, reg_data, pc;
    logic        cont, run;
    logic [31:0] ddu_addr;
    logic [7:0]  an, seg;
    logic [15:0] led, step_cnt;

    always #5 clk = ~clk;

    ddu_debug_unit #(.DEB_CYCLES(DEB), .SCAN_DIV(SD), .ADDR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cont_sw(cont_sw),
        .i_step_btn(step_btn), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn),
        .i_mem_sel(mem_sel), .i_mem_data(mem_data), .i_reg_data(reg_data),
        .i_pc(pc), .o_cont(cont), .o_run(run), .o_ddu_addr(ddu_addr),
        .o_an(an), .o_seg(seg), .o_led(led), .o_step_cnt(step_cnt)
    );

    int checks = 0;
    int failures = 0;
    int runs = 0;

    logic [7:0] hexseg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: sync level = raw input one edge earlier; a button's
    // debounced level flips once the last DEB synchronized samples all disagree.
    logic [3:0]  praw;
    logic [3:0]  winq [$];
    logic [3:0]  m_deb, m_r1, m_r2;
    logic        m_cont, m_cont_p, m_run;
    logic [7:0]  m_addr, m_an, m_seg;
    logic [15:0] m_led, m_cnt;
    int          kpost;

    task automatic model_step();
        logic [3:0]  s_new, d_new, r_new;
        logic        allx, new_run;
        logic [7:0]  new_addr;
        logic [15:0] new_cnt;
        logic [31:0] word;
        int          digit;
        if (!rst_n) begin
            praw = '0; winq.delete(); m_deb = '0; m_r1 = '0; m_r2 = '0;
            m_cont = 0; m_cont_p = 0; m_run = 0; m_addr = '0;
            m_an = 8'hFF; m_seg = 8'hFF; m_led = '0; m_cnt = '0; kpost = 0;
        end else begin
            s_new = praw;
            praw  = {dec_btn, inc_btn, step_btn, cont_sw};
            d_new = m_deb;
            for (int b = 1; b < 4; b++) begin
                if (winq.size() >= DEB) begin
                    allx = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (winq[winq.size()-1-j][b] == m_deb[b]) allx = 1'b0;
                    if (allx) d_new[b] = ~m_deb[b];
                end
            end
            winq.push_back(s_new);
            if (winq.size() > DEB) void'(winq.pop_front());
            r_new    = d_new & ~m_deb;
            new_run  = m_r2[1] & ~m_cont;
            new_addr = m_addr + {7'd0, m_r2[2]} - {7'd0, m_r2[3]};
            new_cnt  = (m_cont & ~m_cont_p) ? 16'd0 : m_cnt + {15'd0, m_run};
            m_led    = {m_addr, pc[9:2]};
            kpost++;
            digit = ((kpost - 1) / SD) % 8;
            word  = mem_sel ? mem_data : reg_data;
            m_an  = ~(8'b1 << digit);
            m_seg = hexseg[word[4*digit +: 4]];
            m_cont_p = m_cont;
            m_cont   = s_new[0];
            m_r2 = m_r1; m_r1 = r_new; m_deb = d_new;
            m_run = new_run; m_addr = new_addr; m_cnt = new_cnt;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] exp_cnt;
`ifdef DDU_STEP_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 16'd0;
`endif
        chk("cont", {31'd0, cont}, {31'd0, m_cont});
        chk("run", {31'd0, run}, {31'd0, m_run});
        chk("ddu_addr", ddu_addr, {24'd0, m_addr});
        chk("an", {24'd0, an}, {24'd0, m_an});
        chk("seg", {24'd0, seg}, {24'd0, m_seg});
        chk("led", {16'd0, led}, {16'd0, m_led});
        chk("step_cnt", {16'd0, step_cnt}, {16'd0, exp_cnt});
    endtask

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            runs += int'(run);
            check_all();
        end
    endtask

    task automatic press(logic [3:0] which);
        {dec_btn, inc_btn, step_btn} = which[3:1];
        tick(10);
        {dec_btn, inc_btn, step_btn} = 3'b000;
        tick(10);
    endtask

    initial begin
        rst_n = 0; cont_sw = 0; step_btn = 0; inc_btn = 0; dec_btn = 0;
        mem_sel = 0; mem_data = $urandom; reg_data = $urandom; pc = $urandom;
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'($urandom); inc_btn = 1'($urandom); dec_btn = 1'($urandom);
            tick();
        end
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_addr", ddu_addr, 32'd0);
        step_btn = 0; inc_btn = 0; dec_btn = 0; rst_n = 1;
        tick();
        chk("an_first", {24'd0, an}, 32'hFE);
        tick(8);

        runs = 0; step_btn = 1;
        tick(7);
        chk("run_early", runs, 0);
        tick();
        chk("run_edge7", {31'd0, run}, 32'd1);
        tick(10);
        chk("run_once", runs, 1);
        step_btn = 0;
        tick(10);
        chk("run_release", runs, 1);

        runs = 0; step_btn = 1;
        tick(3);
        step_btn = 0;
        tick(12);
        chk("glitch", runs, 0);

        cont_sw = 1;
        tick(2);
        chk("cont_lat", {31'd0, cont}, 32'd1);
        runs = 0;
        press(4'b0010);
        chk("cont_norun", runs, 0);
        cont_sw = 0;
        tick(4);

        press(4'b1000);
        chk("dec_wrap", ddu_addr, 32'h0000_00FF);
        press(4'b0100);
        chk("inc_wrap", ddu_addr, 32'd0);
        press(4'b1100);
        chk("inc_dec", ddu_addr, 32'd0);

        runs = 0; step_btn = 1;
        tick(3);
        rst_n = 0;
        tick();
        rst_n = 1;
        tick(7);
        chk("rst_deb_early", runs, 0);
        tick();
        chk("rst_deb_run", {31'd0, run}, 32'd1);
        step_btn = 0;
        tick(10);

        rst_n = 0; mem_sel = 1; mem_data = 32'h1234_ABCD;
        tick();
        rst_n = 1;
        tick();
        chk("dig0_an", {24'd0, an}, 32'hFE);
        chk("dig0_seg", {24'd0, seg}, 32'hA1);
        tick(3);
        chk("dig0_hold", {24'd0, an}, 32'hFE);
        tick();
        chk("dig1_an", {24'd0, an}, 32'hFD);
        chk("dig1_seg", {24'd0, seg}, 32'hC6);
        tick(8);
        chk("dig3_an", {24'd0, an}, 32'hF7);
        chk("dig3_seg", {24'd0, seg}, 32'h88);
        tick(16);
        chk("dig7_an", {24'd0, an}, 32'h7F);
        chk("dig7_seg", {24'd0, seg}, 32'hF9);

        runs = 0;
        press(4'b0010);
        press(4'b0010);
        press(4'b0010);
        chk("three_runs", runs, 3);
`ifdef DDU_STEP_COUNT_EN
        chk("step_cnt3", {16'd0, step_cnt}, 32'd3);
`else
        chk("step_cnt0", {16'd0, step_cnt}, 32'd0);
`endif

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 5) == 0) inc_btn = ~inc_btn;
            if ($urandom_range(0, 5) == 0) dec_btn = ~dec_btn;
            if ($urandom_range(0, 39) == 0) cont_sw = ~cont_sw;
            if ($urandom_range(0, 7) == 0) mem_sel = ~mem_sel;
            mem_data = $urandom; reg_data = $urandom; pc = $urandom;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
